// File: rtl/pet_prg_injector.sv
// PRG loader: parses the 2-byte load address, DMA-writes the payload into PET RAM,
// then points the BASIC end-of-program pointers at the first free byte.
module pet_prg_injector #(
  parameter logic [7:0] PTR_BASE     = 8'h2A,
  parameter int         PTR_COUNT    = 3,
  parameter bit         ALLOW_ROM_WR = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_start,
  input  logic        dl_end,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        err,
  output logic [15:0] end_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_PATCH, S_FIN
  } state_t;

  localparam logic [7:0] PATCH_LAST = 8'(2 * PTR_COUNT - 1);

  state_t      state_q, state_d;
  logic [15:0] load_addr_q, load_addr_d;
  logic [15:0] cur_q, cur_d;
  logic [15:0] end_addr_q, end_addr_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic [7:0]  dma_din_q, dma_din_d;
  logic        dma_we_q, dma_we_d;
  logic        overflow_q, overflow_d;
  logic        err_q, err_d;
  logic        end_seen_q, end_seen_d;
  logic        wrapped_q, wrapped_d;
  logic [7:0]  patch_idx_q, patch_idx_d;
  logic        accept;

  assign in_ready = (state_q == S_HDR_LO || state_q == S_HDR_HI || state_q == S_DATA)
                    && !dma_we_q && !end_seen_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    cur_d       = cur_q;
    end_addr_d  = end_addr_q;
    dma_addr_d  = dma_addr_q;
    dma_din_d   = dma_din_q;
    dma_we_d    = 1'b0;
    overflow_d  = overflow_q;
    err_d       = err_q;
    end_seen_d  = end_seen_q || (dl_end && state_q != S_IDLE);
    wrapped_d   = wrapped_q;
    patch_idx_d = patch_idx_q;

    case (state_q)
      S_IDLE: begin
        if (dl_start) begin
          state_d    = S_HDR_LO;
          overflow_d = 1'b0;
          err_d      = 1'b0;
          end_seen_d = 1'b0;
          wrapped_d  = 1'b0;
        end
      end
      S_HDR_LO: begin
        if (end_seen_q) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (accept) begin
          load_addr_d[7:0] = in_data;
          state_d          = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (end_seen_q) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (accept) begin
          load_addr_d = {in_data, load_addr_q[7:0]};
          cur_d       = {in_data, load_addr_q[7:0]};
          end_addr_d  = {in_data, load_addr_q[7:0]};
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          // once cur has wrapped past $FFFF it stays frozen and every byte is dropped
          if (wrapped_q) begin
            overflow_d = 1'b1;
          end else begin
            if (cur_q[15] && !ALLOW_ROM_WR) begin
              overflow_d = 1'b1;
            end else begin
              dma_we_d   = 1'b1;
              dma_addr_d = cur_q;
              dma_din_d  = in_data;
            end
            cur_d      = cur_q + 16'd1;
            end_addr_d = cur_q + 16'd1;
            if (cur_q == 16'hFFFF) wrapped_d = 1'b1;
          end
        end else if (end_seen_q && !dma_we_q) begin
          patch_idx_d = 8'd0;
          state_d     = (load_addr_q[15] || overflow_q) ? S_FIN : S_PATCH;
        end
      end
      S_PATCH: begin
        dma_we_d    = 1'b1;
        dma_addr_d  = {8'h00, PTR_BASE + patch_idx_q};
        dma_din_d   = patch_idx_q[0] ? end_addr_q[15:8] : end_addr_q[7:0];
        patch_idx_d = patch_idx_q + 8'd1;
        if (patch_idx_q == PATCH_LAST) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // restart while busy: abandon the transfer, keep what was already written
    if (dl_start && state_q != S_IDLE) begin
      state_d    = S_HDR_LO;
      dma_we_d   = 1'b0;
      overflow_d = 1'b0;
      err_d      = 1'b0;
      end_seen_d = 1'b0;
      wrapped_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      load_addr_q <= 16'h0000;
      cur_q       <= 16'h0000;
      end_addr_q  <= 16'h0000;
      dma_addr_q  <= 16'h0000;
      dma_din_q   <= 8'h00;
      dma_we_q    <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
      end_seen_q  <= 1'b0;
      wrapped_q   <= 1'b0;
      patch_idx_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      cur_q       <= cur_d;
      end_addr_q  <= end_addr_d;
      dma_addr_q  <= dma_addr_d;
      dma_din_q   <= dma_din_d;
      dma_we_q    <= dma_we_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
      end_seen_q  <= end_seen_d;
      wrapped_q   <= wrapped_d;
      patch_idx_q <= patch_idx_d;
    end
  end

  assign dma_addr = dma_addr_q;
  assign dma_din  = dma_din_q;
  assign dma_we   = dma_we_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign overflow = overflow_q;
  assign err      = err_q;
  assign end_addr = end_addr_q;

endmodule

// File: tb/tb_pet_prg_injector.sv
// Scoreboard bench for pet_prg_injector: expected DMA writes and completion
// records are queued by the stimulus and checked by a negedge monitor.
module tb_pet_prg_injector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl_start = 1'b0;
  logic        dl_end = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        err;
  logic [15:0] end_addr;

  pet_prg_injector dut (
    .clk(clk), .reset(reset), .dl_start(dl_start), .dl_end(dl_end),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .busy(busy), .done(done), .overflow(overflow), .err(err), .end_addr(end_addr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int we_cycles = 0;
  int done_seen = 0;
  logic [23:0] exp_wr[$];
  logic [18:0] exp_done[$];   // {check_end_addr, overflow, err, end_addr}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (dma_we === 1'b1) begin
      we_cycles++;
      if (exp_wr.size() == 0) chk("unexpected_wr", {8'h00, dma_addr, dma_din}, 32'hFFFFFFFF);
      else chk("dma_wr", {8'h00, dma_addr, dma_din}, {8'h00, exp_wr.pop_front()});
    end
    if (done === 1'b1) begin
      done_seen++;
      if (exp_done.size() == 0) chk("unexpected_done", 32'(done), 32'h0);
      else begin
        logic [18:0] r;
        r = exp_done.pop_front();
        chk("done_busy", 32'(busy), 32'h1);
        chk("done_ovf", 32'(overflow), 32'(r[17]));
        chk("done_err", 32'(err), 32'(r[16]));
        if (r[18]) chk("done_end_addr", 32'(end_addr), 32'(r[15:0]));
      end
    end
  end

  task automatic pulse_start();
    dl_start = 1'b1;
    @(posedge clk); #1;
    dl_start = 1'b0;
  endtask

  task automatic pulse_end();
    dl_end = 1'b1;
    @(posedge clk); #1;
    dl_end = 1'b0;
  endtask

  // Leaves in_valid high on return; caller lowers it at the end of a stream.
  task automatic send(input logic [7:0] b, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_data = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      waits++;
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      chk("send_timeout", 32'(ok), 32'h1);
    end
  endtask

  task automatic wait_done();
    int start;
    bit seen;
    start = done_seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done_seen > start) begin seen = 1'b1; break; end
    end
    chk("done_seen", 32'(seen), 32'h1);
    @(posedge clk); #1;
    chk("busy_after_done", 32'(busy), 32'h0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'h0);
  endtask

  task automatic exp_patch(input logic [15:0] ea);
    for (int k = 0; k < 3; k++) begin
      exp_wr.push_back({8'h00, 8'(8'h2A + 2 * k), ea[7:0]});
      exp_wr.push_back({8'h00, 8'(8'h2B + 2 * k), ea[15:8]});
    end
  endtask

  int w;
  int we_before;
  logic [7:0] v2[4];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dma_we", 32'(dma_we), 32'h0);
    chk("rst_dma_addr", 32'(dma_addr), 32'h0);
    chk("rst_dma_din", 32'(dma_din), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ovf_err", {30'h0, overflow, err}, 32'h0);
    chk("rst_end_addr", 32'(end_addr), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // basic load at $0401
    exp_wr.push_back({16'h0401, 8'hAA});
    exp_wr.push_back({16'h0402, 8'hBB});
    exp_wr.push_back({16'h0403, 8'hCC});
    exp_patch(16'h0404);
    exp_done.push_back({1'b1, 1'b0, 1'b0, 16'h0404});
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'h1);
    send(8'h01, w); send(8'h04, w);
    send(8'hAA, w); send(8'hBB, w); send(8'hCC, w);
    in_valid = 1'b0;
    pulse_end();
    wait_done();

    // continuous valid: one byte per two cycles
    v2[0] = 8'h10; v2[1] = 8'h20; v2[2] = 8'h30; v2[3] = 8'h40;
    for (int i = 0; i < 4; i++) exp_wr.push_back({16'(16'h0600 + i), v2[i]});
    exp_patch(16'h0604);
    exp_done.push_back({1'b1, 1'b0, 1'b0, 16'h0604});
    pulse_start();
    send(8'h00, w); send(8'h06, w);
    for (int i = 0; i < 4; i++) begin
      send(v2[i], w);
      if (i > 0) chk("stream_gap", 32'(w), 32'd2);
    end
    in_valid = 1'b0;
    pulse_end();
    wait_done();

    // crossing into ROM space: drops, overflow, no patch
    exp_wr.push_back({16'h7FFE, 8'h11});
    exp_wr.push_back({16'h7FFF, 8'h22});
    exp_done.push_back({1'b1, 1'b1, 1'b0, 16'h8002});
    pulse_start();
    send(8'hFE, w); send(8'h7F, w);
    send(8'h11, w); send(8'h22, w); send(8'h33, w); send(8'h44, w);
    in_valid = 1'b0;
    pulse_end();
    wait_done();

    // truncated header
    we_before = we_cycles;
    exp_done.push_back({1'b0, 1'b0, 1'b1, 16'h0000});
    pulse_start();
    send(8'h01, w);
    in_valid = 1'b0;
    pulse_end();
    wait_done();
    chk("hdr_err_no_we", 32'(we_cycles - we_before), 32'h0);

    // restart mid-DATA after an overflow
    exp_wr.push_back({16'h7FFF, 8'h01});
    exp_wr.push_back({16'h1000, 8'h55});
    exp_patch(16'h1001);
    exp_done.push_back({1'b1, 1'b0, 1'b0, 16'h1001});
    pulse_start();
    send(8'hFF, w); send(8'h7F, w); send(8'h01, w); send(8'h02, w);
    in_valid = 1'b0;
    chk("pre_abort_ovf", 32'(overflow), 32'h1);
    pulse_start();
    chk("abort_ovf_clr", 32'(overflow), 32'h0);
    chk("abort_err_clr", 32'(err), 32'h0);
    chk("abort_busy", 32'(busy), 32'h1);
    send(8'h00, w); send(8'h10, w); send(8'h55, w);
    in_valid = 1'b0;
    pulse_end();
    wait_done();

    // reset during the second data byte's write cycle
    exp_wr.push_back({16'h2000, 8'h10});
    exp_wr.push_back({16'h2001, 8'h20});
    pulse_start();
    send(8'h00, w); send(8'h20, w); send(8'h10, w); send(8'h20, w);
    in_valid = 1'b0;
    chk("midrst_we_pending", 32'(dma_we), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_we", 32'(dma_we), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_in_ready", 32'(in_ready), 32'h0);
    chk("midrst_end_addr", 32'(end_addr), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_wr_drained", 32'(exp_wr.size()), 32'h0);
    exp_wr.push_back({16'h3000, 8'h77});
    exp_patch(16'h3001);
    exp_done.push_back({1'b1, 1'b0, 1'b0, 16'h3001});
    pulse_start();
    send(8'h00, w); send(8'h30, w); send(8'h77, w);
    in_valid = 1'b0;
    pulse_end();
    wait_done();

    chk("done_queue_empty", 32'(exp_done.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
